// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: state encoding,
// the bundle of stage-register controls and the canned control patterns.
package hazard_ctrl_pkg;

    localparam int REG_W           = 5;
    localparam int DEF_MDU_TIMEOUT = 64;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic ex_mem_bubble;
        logic mem_wb_en;
    } ctl_t;

    function automatic ctl_t ctl_default();
        ctl_t c;
        c = '0;
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
        return c;
    endfunction

    // Reset keeps every register loading so the pipeline fills with bubbles.
    function automatic ctl_t ctl_reset();
        return '1;
    endfunction

    function automatic ctl_t ctl_freeze_all();
        return '0;
    endfunction

    // MDU op parked in EX: front end holds, EX/MEM receives bubbles, tail drains.
    function automatic ctl_t ctl_mdu_freeze();
        ctl_t c;
        c = '0;
        c.ex_mem_en     = 1'b1;
        c.ex_mem_bubble = 1'b1;
        c.mem_wb_en     = 1'b1;
        return c;
    endfunction

    function automatic ctl_t ctl_branch_flush();
        ctl_t c;
        c = ctl_default();
        c.if_id_flush  = 1'b1;
        c.id_ex_bubble = 1'b1;
        return c;
    endfunction

    function automatic ctl_t ctl_load_use();
        ctl_t c;
        c = ctl_default();
        c.pc_en        = 1'b0;
        c.if_id_en     = 1'b0;
        c.id_ex_bubble = 1'b1;
        return c;
    endfunction

    // Priority evaluation of the free-running pipeline once memory is ready.
    function automatic ctl_t run_ctl(
        input logic mdu_start,
        input logic mdu_done,
        input logic branch_taken,
        input logic load_use
    );
        if (mdu_start) begin
            return mdu_done ? ctl_default() : ctl_mdu_freeze();
        end
        if (branch_taken) begin
            return ctl_branch_flush();
        end
        if (load_use) begin
            return ctl_load_use();
        end
        return ctl_default();
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use compare between the load in EX and the source operands in ID.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt && (ex_rt == id_rt);
        // Register 0 is hardwired, so a load targeting it never creates a hazard.
        load_use = ex_mem_read && id_valid && (ex_rt != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes and bubbles for load-use,
// taken branches, data-memory wait states and multi-cycle MDU ops.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = DEF_MDU_TIMEOUT,
    parameter int STALL_W     = 32,
    parameter int FLUSH_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               id_uses_rt,
    input  logic               ex_mem_read,
    input  logic [REG_W-1:0]   ex_rt,
    input  logic               ex_branch_taken,
    input  logic               ex_mdu_start,
    input  logic               mdu_done,
    input  logic               mem_busy,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               if_id_flush,
    output logic               id_ex_en,
    output logic               id_ex_bubble,
    output logic               ex_mem_en,
    output logic               ex_mem_bubble,
    output logic               mem_wb_en,
    output logic [1:0]         state,
    output logic [STALL_W-1:0] stall_cnt,
    output logic [FLUSH_W-1:0] flush_cnt,
    output logic               mdu_err
);

    localparam int WAIT_W = $clog2(MDU_TIMEOUT + 1) + 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MDU_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               done_pend_q, done_pend_d;
    logic               mdu_err_q, mdu_err_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;

    logic               load_use;
    logic               timeout;
    logic [WAIT_W-1:0]  wait_inc;
    ctl_t               ctl;

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    // The counter keeps running under mem_busy, so it can pass the limit
    // before the timeout check gets a turn; compare with >= not ==.
    assign timeout  = (wait_cnt_q >= TIMEOUT_V);
    assign wait_inc = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            done_pend_q <= 1'b0;
            mdu_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            done_pend_q <= done_pend_d;
            mdu_err_q   <= mdu_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        done_pend_d = done_pend_q;
        mdu_err_d   = mdu_err_q;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                end else if (ex_mdu_start && !mdu_done) begin
                    state_d    = MDU_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            MDU_WAIT: begin
                if (mem_busy) begin
                    wait_cnt_d  = wait_inc;
                    done_pend_d = done_pend_q || mdu_done;
                end else if (mdu_done || done_pend_q) begin
                    state_d     = RUN;
                    done_pend_d = 1'b0;
                    wait_cnt_d  = '0;
                end else if (timeout) begin
                    state_d    = RUN;
                    mdu_err_d  = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        ctl = ctl_default();
        if (rst) begin
            ctl = ctl_reset();
        end else begin
            unique case (state_q)
                RUN, MEM_WAIT: begin
                    if (mem_busy) begin
                        ctl = ctl_freeze_all();
                    end else begin
                        ctl = run_ctl(ex_mdu_start, mdu_done, ex_branch_taken, load_use);
                    end
                end
                MDU_WAIT: begin
                    if (mem_busy) begin
                        ctl = ctl_freeze_all();
                    end else if (mdu_done || done_pend_q || timeout) begin
                        ctl = ctl_default();
                    end else begin
                        ctl = ctl_mdu_freeze();
                    end
                end
                default: begin
                    ctl = ctl_default();
                end
            endcase
        end
    end

    // Outside reset, if_id_flush only ever comes from a taken branch.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctl.pc_en && (stall_cnt_q != {STALL_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
        if (ctl.if_id_flush && (flush_cnt_q != {FLUSH_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
    end

    assign pc_en         = ctl.pc_en;
    assign if_id_en      = ctl.if_id_en;
    assign if_id_flush   = ctl.if_id_flush;
    assign id_ex_en      = ctl.id_ex_en;
    assign id_ex_bubble  = ctl.id_ex_bubble;
    assign ex_mem_en     = ctl.ex_mem_en;
    assign ex_mem_bubble = ctl.ex_mem_bubble;
    assign mem_wb_en     = ctl.mem_wb_en;
    assign state         = state_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign mdu_err       = mdu_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a rule-level model of the controller.
module tb_hazard_ctrl;

    localparam int TO = 8;

    // Control vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
    // ex_mem_en, ex_mem_bubble, mem_wb_en.
    localparam bit [7:0] V_DEF   = 8'b1101_0101;
    localparam bit [7:0] V_RST   = 8'b1111_1111;
    localparam bit [7:0] V_FRZ   = 8'b0000_0000;
    localparam bit [7:0] V_MDU   = 8'b0000_0111;
    localparam bit [7:0] V_FLUSH = 8'b1111_1101;
    localparam bit [7:0] V_LU    = 8'b0001_1101;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rt, ex_mem_read;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_branch_taken, ex_mdu_start, mdu_done, mem_busy;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic        ex_mem_en, ex_mem_bubble, mem_wb_en;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        mdu_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 running, 1 waiting on memory, 2 waiting on the MDU.
    int     m_mode;
    int     m_waited;
    bit     m_pend;
    longint m_stalls;
    longint m_flushes;
    bit     m_err;

    hazard_ctrl #(.MDU_TIMEOUT(TO), .STALL_W(32), .FLUSH_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
        .mdu_done(mdu_done), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .ex_mem_en(ex_mem_en), .ex_mem_bubble(ex_mem_bubble), .mem_wb_en(mem_wb_en),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mdu_err(mdu_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_pend = 0;
        m_stalls = 0; m_flushes = 0; m_err = 0;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0;
        ex_mdu_start = 0; mdu_done = 0; mem_busy = 0;
    endtask

    // One clock: check mid-cycle against the model, then advance the model.
    task automatic cycle();
        bit [7:0] e;
        int  n_mode, n_waited;
        bit  n_pend, n_err, lu;
        #3;
        assert (!(ex_branch_taken && ex_mdu_start))
            else $error("stimulus drove branch and MDU start together");
        e = V_DEF; n_mode = m_mode; n_waited = m_waited; n_pend = m_pend; n_err = m_err;
        lu = ex_mem_read && id_valid && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (rst) begin
            e = V_RST;
        end else if (mem_busy) begin
            e = V_FRZ;
            if (m_mode == 2) begin
                n_waited = m_waited + 1;
                n_pend = m_pend || mdu_done;
            end else begin
                n_mode = 1;
            end
        end else if (m_mode != 2) begin
            n_mode = 0;
            if (ex_mdu_start && !mdu_done) begin e = V_MDU; n_mode = 2; n_waited = 1; end
            else if (ex_mdu_start)         e = V_DEF;
            else if (ex_branch_taken)      e = V_FLUSH;
            else if (lu)                   e = V_LU;
        end else if (mdu_done || m_pend) begin
            n_mode = 0; n_pend = 0;
        end else if (m_waited >= TO) begin
            n_mode = 0; n_err = 1;
        end else begin
            e = V_MDU; n_waited = m_waited + 1;
        end
        chk("ctl", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                    ex_mem_en, ex_mem_bubble, mem_wb_en}, e);
        chk("state", state, m_mode);
        chk("stall_cnt", stall_cnt, m_stalls);
        chk("flush_cnt", flush_cnt, m_flushes);
        chk("mdu_err", mdu_err, m_err);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!e[7] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            if (e == V_FLUSH && m_flushes < 64'hFFFF) m_flushes++;
            m_mode = n_mode; m_waited = n_waited; m_pend = n_pend; m_err = n_err;
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();

        cycle(); cycle();
        rst = 0;
        chk("reset_state", state, 0);
        chk("reset_stall", stall_cnt, 0);

        cycle();
        ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_valid = 1;
        cycle();
        chk("lu_stall", stall_cnt, 1);
        ex_rt = 0;
        cycle();
        chk("lu_r0_stall", stall_cnt, 1);

        ex_rt = 5; ex_branch_taken = 1;
        cycle();
        clear_inputs();
        chk("br_flush", flush_cnt, 1);
        chk("br_stall", stall_cnt, 1);

        ex_mdu_start = 1;
        repeat (4) cycle();
        mdu_done = 1;
        cycle();
        clear_inputs();
        cycle();
        chk("mdu_stall", stall_cnt, 5);
        chk("mdu_state", state, 0);

        ex_mdu_start = 1;
        repeat (9) cycle();
        clear_inputs();
        cycle();
        chk("wd_stall", stall_cnt, 13);
        chk("wd_err", mdu_err, 1);

        ex_mdu_start = 1;
        cycle(); cycle();
        mem_busy = 1; cycle();
        mdu_done = 1; cycle();
        mdu_done = 0; cycle();
        mem_busy = 0; cycle();
        clear_inputs();
        chk("pend_stall", stall_cnt, 18);
        chk("pend_state", state, 0);

        mem_busy = 1;
        cycle(); cycle();
        mem_busy = 0;
        cycle();
        chk("mem_stall", stall_cnt, 20);
        chk("mem_err_sticky", mdu_err, 1);

        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            mem_busy        = ($urandom_range(0, 5) == 0);
            if (m_mode != 2) ex_mdu_start = ($urandom_range(0, 9) == 0);
            mdu_done        = ($urandom_range(0, 7) == 0);
            ex_branch_taken = !ex_mdu_start && ($urandom_range(0, 3) == 0);
            ex_mem_read     = 1'($urandom_range(0, 1));
            id_valid        = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_rt           = 5'($urandom_range(0, 3));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            cycle();
        end

        clear_inputs();
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        chk("final_err_cleared", mdu_err, 0);
        chk("final_stall", stall_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
